// File: rtl/pow_job_scheduler.sv
// -----------------------------------------------------------------------------
// pow_job_scheduler
//   Sequences one mining job across NUM_CORES hash cores that share a single
//   increment source. On a job load the scheduler enters RUN. In RUN it grants
//   one requesting core per cycle in round-robin order. Each grant carries a
//   unique increment taken from a counter that advances by STRIDE per grant.
//   The job stops on a hit, an abort or counter exhaustion. The scheduler then
//   waits for the in-flight cores to go idle and holds the result until the
//   host acknowledges it.
//
//   Optional feature: define POW_SCHED_PERF_EN to enable the per-job grant
//   counter on o_grant_count. The counter saturates at 32'hFFFF_FFFF. When the
//   macro is not defined, o_grant_count is tied to 0.
//
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_job_valid           job load request (accepted in IDLE only)
//   o_job_ready           high only in IDLE
//   i_abort               stop the running job without a result
//   i_core_req[k]         core k requests a new increment
//   i_core_busy[k]        core k has work in flight
//   o_grant               one-hot grant, qualified by o_inc_valid
//   o_inc_valid, o_inc    increment for the granted core (zero-extended to 256 b)
//   i_found, i_found_inc  hit pulse and the increment that produced the hit
//   o_done                result valid, held until i_ack
//   o_found, o_exhausted  result flags (valid with o_done)
//   o_result_inc          latched hit increment
//   i_ack                 host consumed the result
//   o_grant_count         grants issued during the current job
// -----------------------------------------------------------------------------
module pow_job_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 64,
    parameter int STRIDE    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_job_valid,
    output logic                 o_job_ready,
    input  logic                 i_abort,
    input  logic [NUM_CORES-1:0] i_core_req,
    input  logic [NUM_CORES-1:0] i_core_busy,
    output logic [NUM_CORES-1:0] o_grant,
    output logic                 o_inc_valid,
    output logic [255:0]         o_inc,
    input  logic                 i_found,
    input  logic [CNT_W-1:0]     i_found_inc,
    output logic                 o_done,
    output logic                 o_found,
    output logic                 o_exhausted,
    output logic [CNT_W-1:0]     o_result_inc,
    input  logic                 i_ack,
    output logic [31:0]          o_grant_count
);

    localparam int IDX_W = $clog2(NUM_CORES);
    // A grant taken while the counter is above this value consumes the last
    // full STRIDE window of the counter space.
    localparam logic [CNT_W-1:0] CNT_LIM = {CNT_W{1'b1}} - CNT_W'(STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic                   job_ready_q;
    logic [NUM_CORES-1:0]   grant_q;
    logic                   inc_valid_q;
    logic [CNT_W-1:0]       inc_q;
    logic                   done_q, found_q, exhausted_q;
    logic [CNT_W-1:0]       result_q;

    logic                   req_any;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W:0]         scan_idx;
    logic                   job_load, grant_fire;

    // Round-robin pick: scan from rr_q upward with wrap-around. The first
    // requester found wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned and infers a latch.
        req_any  = 1'b0;
        sel_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            scan_idx = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan_idx >= (IDX_W+1)'(NUM_CORES))
                scan_idx = scan_idx - (IDX_W+1)'(NUM_CORES);
            if (!req_any && i_core_req[scan_idx]) begin
                req_any = 1'b1;
                sel_idx = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign rr_d  = (sel_idx == IDX_W'(NUM_CORES - 1)) ? '0 : sel_idx + IDX_W'(1);
    assign cnt_d = cnt_q + CNT_W'(STRIDE);

    assign job_load   = (state_q == S_IDLE) && i_job_valid;
    // A hit or an abort takes priority over a grant in the same cycle.
    assign grant_fire = (state_q == S_RUN) && !i_found && !i_abort && req_any;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            job_ready_q <= 1'b1;
            grant_q     <= '0;
            inc_valid_q <= 1'b0;
            inc_q       <= '0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            result_q    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every read in this
            // block sees the pre-edge value regardless of statement order.
            grant_q     <= '0;
            inc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (job_load) begin
                        state_q     <= S_RUN;
                        job_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        rr_q        <= '0;
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        result_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (i_found) begin
                        found_q  <= 1'b1;
                        result_q <= i_found_inc;
                        state_q  <= S_DRAIN;
                    end else if (i_abort) begin
                        state_q <= S_DRAIN;
                    end else if (grant_fire) begin
                        grant_q     <= NUM_CORES'(1) << sel_idx;
                        inc_valid_q <= 1'b1;
                        inc_q       <= cnt_q;
                        cnt_q       <= cnt_d;
                        rr_q        <= rr_d;
                        // The grant that crosses the limit is still issued.
                        if (cnt_q > CNT_LIM) begin
                            exhausted_q <= 1'b1;
                            state_q     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // A core still in flight may report a hit. The first hit
                    // is kept.
                    if (i_found && !found_q) begin
                        found_q  <= 1'b1;
                        result_q <= i_found_inc;
                    end
                    if (i_core_busy == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ack) begin
                        state_q     <= S_IDLE;
                        done_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        result_q    <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef POW_SCHED_PERF_EN
    logic [31:0] gcnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            gcnt_q <= '0;
        else if (job_load)
            gcnt_q <= '0;
        else if (grant_fire && (gcnt_q != 32'hFFFF_FFFF))
            gcnt_q <= gcnt_q + 32'd1;
    end

    assign o_grant_count = gcnt_q;
`else
    assign o_grant_count = 32'd0;
`endif

    assign o_job_ready  = job_ready_q;
    assign o_grant      = grant_q;
    assign o_inc_valid  = inc_valid_q;
    assign o_inc        = 256'(inc_q);
    assign o_done       = done_q;
    assign o_found      = found_q;
    assign o_exhausted  = exhausted_q;
    assign o_result_inc = result_q;

endmodule

// File: tb/tb_pow_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pow_job_scheduler
//   Directed bench for pow_job_scheduler. It uses two instances:
//   - dut_a (CNT_W=64) covers grants, round-robin order, hit, abort, late hit
//     and reset.
//   - dut_b (CNT_W=8) covers counter exhaustion.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at the
//   same point.
// -----------------------------------------------------------------------------
module tb_pow_job_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a signals
    logic         a_job_valid, a_job_ready, a_abort, a_found, a_done, a_found_o;
    logic         a_exhausted, a_ack, a_inc_valid;
    logic [3:0]   a_req, a_busy, a_grant;
    logic [255:0] a_inc;
    logic [63:0]  a_found_inc, a_result;
    logic [31:0]  a_gcnt;

    // dut_b signals
    logic         b_job_valid, b_job_ready, b_abort, b_found, b_done, b_found_o;
    logic         b_exhausted, b_ack, b_inc_valid;
    logic [3:0]   b_req, b_busy, b_grant;
    logic [255:0] b_inc;
    logic [7:0]   b_found_inc, b_result;
    logic [31:0]  b_gcnt;

    pow_job_scheduler #(.NUM_CORES(4), .CNT_W(64), .STRIDE(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_job_valid(a_job_valid), .o_job_ready(a_job_ready), .i_abort(a_abort),
        .i_core_req(a_req), .i_core_busy(a_busy), .o_grant(a_grant),
        .o_inc_valid(a_inc_valid), .o_inc(a_inc),
        .i_found(a_found), .i_found_inc(a_found_inc),
        .o_done(a_done), .o_found(a_found_o), .o_exhausted(a_exhausted),
        .o_result_inc(a_result), .i_ack(a_ack), .o_grant_count(a_gcnt)
    );

    pow_job_scheduler #(.NUM_CORES(4), .CNT_W(8), .STRIDE(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_job_valid(b_job_valid), .o_job_ready(b_job_ready), .i_abort(b_abort),
        .i_core_req(b_req), .i_core_busy(b_busy), .o_grant(b_grant),
        .o_inc_valid(b_inc_valid), .o_inc(b_inc),
        .i_found(b_found), .i_found_inc(b_found_inc),
        .o_done(b_done), .o_found(b_found_o), .o_exhausted(b_exhausted),
        .o_result_inc(b_result), .i_ack(b_ack), .o_grant_count(b_gcnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_load();
        a_job_valid = 1'b1;
        tick();
        a_job_valid = 1'b0;
    endtask

    task automatic a_acknowledge();
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
    endtask

    int          b_grants;
    logic [7:0]  b_last;
    logic        b_mono_bad;

    initial begin
        rst_n = 1'b0;
        a_job_valid = 0; a_abort = 0; a_found = 0; a_ack = 0;
        a_req = '0; a_busy = '0; a_found_inc = '0;
        b_job_valid = 0; b_abort = 0; b_found = 0; b_ack = 0;
        b_req = '0; b_busy = '0; b_found_inc = '0;

        // Reset values
        #12;
        check("rst_ready", a_job_ready, 1);
        check("rst_valid", a_inc_valid, 0);
        check("rst_grant", a_grant, 0);
        check("rst_done",  a_done, 0);
        check("rst_gcnt",  a_gcnt, 0);
        tick();
        rst_n = 1'b1;

        // Abort in IDLE has no effect
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("idle_abort_ready", a_job_ready, 1);
        check("idle_abort_done",  a_done, 0);

        // All four cores request: expect grants 0,1,2,3,0 with increments 0..4
        a_load();
        check("run_ready", a_job_ready, 0);
        a_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), a_grant, 4'b0001 << (k % 4));
            check($sformatf("rr_inc%0d", k),   a_inc, k);
            check($sformatf("rr_valid%0d", k), a_inc_valid, 1);
        end
        a_req = '0;
        tick();
        check("noreq_valid", a_inc_valid, 0);
`ifdef POW_SCHED_PERF_EN
        check("gcnt5", a_gcnt, 5);
`else
        check("gcnt_tied", a_gcnt, 0);
`endif

        // Only core 2 requests: granted each cycle, increments continue 5,6,7
        a_req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("c2_grant%0d", k), a_grant, 4'b0100);
            check($sformatf("c2_inc%0d", k),   a_inc, 5 + k);
        end

        // Hit while cores 0,1 are busy: grants stop, wait for drain
        a_req = 4'hF; a_busy = 4'b0011;
        a_found = 1'b1; a_found_inc = 64'h1234;
        tick();
        a_found = 1'b0;
        check("found_nogrant", a_inc_valid, 0);
        tick(); tick();
        check("drain_nogrant", a_inc_valid, 0);
        check("drain_notdone", a_done, 0);
        a_busy = '0;
        tick();
        a_req = '0;
        check("hit_done",   a_done, 1);
        check("hit_found",  a_found_o, 1);
        check("hit_result", a_result, 64'h1234);
        check("hit_exh",    a_exhausted, 0);
        tick();
        check("done_hold", a_done, 1);
        a_acknowledge();
        check("ack_done",  a_done, 0);
        check("ack_ready", a_job_ready, 1);
        check("ack_found", a_found_o, 0);

        // Hit and abort in the same cycle: the hit wins
        a_load();
        a_found = 1'b1; a_abort = 1'b1; a_found_inc = 64'h55;
        tick();
        a_found = 1'b0; a_abort = 1'b0;
        tick();
        check("fa_done",   a_done, 1);
        check("fa_found",  a_found_o, 1);
        check("fa_result", a_result, 64'h55);
        a_acknowledge();

        // Abort alone: done without a hit
        a_load();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        tick();
        check("ab_done",  a_done, 1);
        check("ab_found", a_found_o, 0);
        check("ab_exh",   a_exhausted, 0);
        a_acknowledge();

        // Late hit during DRAIN after an abort
        a_load();
        a_busy = 4'b1000; a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        a_found = 1'b1; a_found_inc = 64'h77;
        tick();
        a_found = 1'b0; a_busy = '0;
        tick();
        check("late_done",   a_done, 1);
        check("late_found",  a_found_o, 1);
        check("late_result", a_result, 64'h77);
        a_acknowledge();

        // Reset asserted mid-RUN
        a_load();
        a_req = 4'hF;
        tick(); tick();
        check("prerst_valid", a_inc_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", a_job_ready, 1);
        check("mrst_valid", a_inc_valid, 0);
        check("mrst_grant", a_grant, 0);
        check("mrst_gcnt",  a_gcnt, 0);
        tick();
        check("mrst_ready2", a_job_ready, 1);
        a_req = '0;
        rst_n = 1'b1;
        tick();

        // CNT_W=8 exhaustion with one core requesting continuously
        b_job_valid = 1'b1;
        tick();
        b_job_valid = 1'b0;
        b_req = 4'b0001;
        b_grants = 0; b_last = '0; b_mono_bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (b_inc_valid) begin
                if (b_grants > 0 && b_inc[7:0] != b_last + 8'd1) b_mono_bad = 1'b1;
                b_last = b_inc[7:0];
                b_grants++;
            end
            if (b_done) break;
        end
        b_req = '0;
        check("exh_done",   b_done, 1);
        check("exh_grants", b_grants, 256);
        check("exh_last",   b_last, 8'hFF);
        check("exh_mono",   b_mono_bad, 0);
        check("exh_flag",   b_exhausted, 1);
        check("exh_found",  b_found_o, 0);
`ifdef POW_SCHED_PERF_EN
        check("exh_gcnt", b_gcnt, 256);
`endif
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("exh_ack_ready", b_job_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
